// File: rtl/ntt_pkg.sv
// Shared NTT constants and the Gentleman-Sande butterfly state type.
package ntt_pkg;
    localparam int WIDTH    = 32;
    localparam int Q        = 3329;
    localparam int MUL_BITS = $clog2(Q);
    localparam int INV2     = (Q + 1) / 2;

    typedef enum logic [1:0] {IDLE, MUL, DONE} gs_state_t;
endpackage

// File: rtl/mod_add.sv
// Combinational (x + y) mod Q for operands already reduced below Q.
module mod_add #(
    parameter int WIDTH = 32,
    parameter int Q     = 3329
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] s
);
    logic [WIDTH:0] sum;

    assign sum = {1'b0, x} + {1'b0, y};
    // The reduced result always fits in WIDTH bits, so subtract in the narrow domain.
    assign s   = (sum >= (WIDTH+1)'(Q)) ? sum[WIDTH-1:0] - WIDTH'(Q) : sum[WIDTH-1:0];
endmodule

// File: rtl/mod_sub.sv
// Combinational (x - y) mod Q for operands already reduced below Q.
module mod_sub #(
    parameter int WIDTH = 32,
    parameter int Q     = 3329
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] d
);
    // x + Q - y may wrap mod 2^WIDTH in the middle, but the final value is exact.
    assign d = (x >= y) ? x - y : x + WIDTH'(Q) - y;
endmodule

// File: rtl/gs_butterfly_seq.sv
// Sequential GS butterfly: u = a+b, v = (a-b)*w mod Q via bit-serial double-and-add.
// Build option: GS_BUTTERFLY_HALVE_EN scales u and v by 2^-1 mod Q on registration.
module gs_butterfly_seq
    import ntt_pkg::*;
#(
    parameter int P_WIDTH    = WIDTH,
    parameter int P_Q        = Q,
    parameter int P_MUL_BITS = MUL_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [P_WIDTH-1:0] a,
    input  logic [P_WIDTH-1:0] b,
    input  logic [P_WIDTH-1:0] w,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [P_WIDTH-1:0] u,
    output logic [P_WIDTH-1:0] v
);
    localparam int CW = (P_MUL_BITS > 1) ? $clog2(P_MUL_BITS) : 1;
    localparam int IW = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1;

    gs_state_t         state, state_nx;
    logic [P_WIDTH-1:0] acc, t, wreg;
    logic [CW-1:0]      cnt;
    logic               fin;
    logic [P_WIDTH-1:0] sum_ab, diff_ab, s2, addend, acc_nx;
    logic [IW-1:0]      bidx;

`ifdef GS_BUTTERFLY_HALVE_EN
    function automatic logic [P_WIDTH-1:0] scale(input logic [P_WIDTH-1:0] x);
        return x[0] ? P_WIDTH'(({1'b0, x} + (P_WIDTH+1)'(P_Q)) >> 1) : x >> 1;
    endfunction
`else
    function automatic logic [P_WIDTH-1:0] scale(input logic [P_WIDTH-1:0] x);
        return x;
    endfunction
`endif

    mod_add #(.WIDTH(P_WIDTH), .Q(P_Q)) u_add_ab  (.x(a),   .y(b),      .s(sum_ab));
    mod_sub #(.WIDTH(P_WIDTH), .Q(P_Q)) u_sub_ab  (.x(a),   .y(b),      .d(diff_ab));
    mod_add #(.WIDTH(P_WIDTH), .Q(P_Q)) u_add_dbl (.x(acc), .y(acc),    .s(s2));
    mod_add #(.WIDTH(P_WIDTH), .Q(P_Q)) u_add_acc (.x(s2),  .y(addend), .s(acc_nx));

    assign bidx   = IW'(cnt);
    assign addend = wreg[bidx] ? t : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = MUL;
            MUL:     if (fin)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // MUL runs MUL_BITS multiply steps, then one cycle to register v.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u    <= '0;
            v    <= '0;
            t    <= '0;
            wreg <= '0;
            acc  <= '0;
            cnt  <= '0;
            fin  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    u    <= scale(sum_ab);
                    t    <= diff_ab;
                    wreg <= w;
                    acc  <= '0;
                    cnt  <= CW'(P_MUL_BITS - 1);
                    fin  <= 1'b0;
                end
                MUL: if (!fin) begin
                    acc <= acc_nx;
                    if (cnt == '0) fin <= 1'b1;
                    else           cnt <= cnt - 1'b1;
                end else begin
                    v <= scale(acc);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gs_butterfly_seq.sv
// Directed scoreboard bench for gs_butterfly_seq (Q=3329, 12-bit serial multiply).
module tb_gs_butterfly_seq;
    localparam int QM  = 3329;
    localparam int LAT = 13;

    typedef struct {
        logic [31:0] u;
        logic [31:0] v;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, w, u, v;
    res_t        sbq[$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    gs_butterfly_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .w(w), .out_valid(out_valid), .out_ready(out_ready),
        .u(u), .v(v)
    );

    function automatic int half(input int x);
`ifdef GS_BUTTERFLY_HALVE_EN
        return (x % 2 == 0) ? x / 2 : (x + QM) / 2;
`else
        return x;
`endif
    endfunction

    function automatic res_t model(input int ai, input int bi, input int wi);
        res_t r;
        r.u = 32'(half((ai + bi) % QM));
        r.v = 32'(half((((ai - bi + QM) % QM) * wi) % QM));
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int ai, input int bi, input int wi, input bit push);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        a = 32'(ai); b = 32'(bi); w = 32'(wi);
        in_valid = 1'b1;
        if (push) sbq.push_back(model(ai, bi, wi));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; counts edges until out_valid rises.
    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        if (!out_valid) check("out_valid_timeout", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic collect(input string tag);
        int   n;
        res_t e;
        wait_out(n);
        check({tag, "_latency"}, 32'(n), 32'(LAT));
        if (sbq.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            check({tag, "_u"}, u, e.u);
            check({tag, "_v"}, v, e.v);
        end
        @(posedge clk); #1;
        check({tag, "_drained"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        int   seen;
        int   n;
        res_t e;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; w = '0;
        #12;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_u", u, 32'd0);
        check("rst_v", v, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        send(5, 3, 1, 1);          collect("basic");
        send(3, 5, 1, 1);          collect("wrap");
        send(3328, 3328, 3328, 1); collect("max");
        send(10, 4, 17, 1);        collect("mul");
        send(100, 7, 0, 1);        collect("w0");
        send(2000, 2000, 77, 1);   collect("aeqb");
        for (int i = 0; i < 4; i++) begin
            send(int'($urandom_range(0, QM-1)), int'($urandom_range(0, QM-1)),
                 int'($urandom_range(0, QM-1)), 1);
            collect("rand");
        end

        // Backpressure: result held, busy, and a stray operand set ignored.
        out_ready = 1'b0;
        send(9, 2, 5, 1);
        wait_out(n);
        e = sbq.pop_front();
        a = 32'd1; b = 32'd1; w = 32'd1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_u", u, e.u);
            check("bp_v", v, e.v);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
        check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("bp_no_dup", 32'(seen), 32'd0);

        // Reset in the middle of the multiply discards the in-flight result.
        send(20, 3, 9, 0);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        check("midrst_u", u, 32'd0);
        check("midrst_v", v, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        send(7, 2, 2, 1);          collect("post_rst");

        check("sb_leftover", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
